alarm_ctrl_nzone: RTL and testbench
===================================

# alarm_ctrl_nzone

Parametrised multi-zone vehicle alarm controller with an integrated delay timer. Monitors `N_DOORS` door/zone inputs plus ignition; arms automatically after the driver exits, enforces per-zone entry delays, drives the siren and status LED, and records which zones tripped. It sits between the debounced sensor inputs and the siren/LED/display drivers, fed by the system 1 Hz enable.

## Interface
Parameters:
- `N_DOORS`, 4: number of door/zone inputs (2..16).
- `DRIVER_IDX`, 0: bit of `doors` that is the driver door.
- `T_ARM`, 6: arm delay in seconds (≥1).
- `T_DRIVER`, 8: entry delay when the driver door opens (≥1).
- `T_PASS`, 15: entry delay when any other zone opens (≥1).
- `T_ALARM_ON`, 10: siren hold time after all zones close (≥1).
- `TW`, 5: timer width; every `T_*` < 2^TW.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ignition` in 1: ignition on.
- `doors` in N_DOORS: 1 = door open; synchronous and debounced.
- `zone_mask` in N_DOORS: 1 = zone may trigger the alarm.
- `one_hz_enable` in 1: one-cycle pulse per second.
- `reprogram` in 1: force armed (SET).
- `status` out 1: status LED.
- `enable_siren` out 1: siren drive.
- `state` out 3: main state code.
- `arm_state` out 2: arming FSM state code.
- `trip_zone` out N_DOORS: latched zones that caused or joined the alarm.
- `trip_count` out 4: saturating count of TRIGGER→ON events.
- `timer_value` out TW: current timer count.

## Operation
- Definitions: `act = doors & zone_mask`; `drv = doors[DRIVER_IDX]`.
- Main FSM states: SET=0, OFF=1, TRIGGER=2, ON=3, STOP_ALARM=4. Codes 5–7 go to SET.
- Priority of next-state logic: `reprogram` → SET; else `ignition` → OFF; else:
  - SET: `|act` → TRIGGER.
  - OFF: `expired && arm_state==START_ARM_DELAY` → SET.
  - TRIGGER: `expired` → ON.
  - ON: `act==0` → STOP_ALARM.
  - STOP_ALARM: `expired` → SET; else `|act` → ON. Expiry wins over a simultaneous door opening.
- Arming FSM states (runs in every main state): WAIT_IGNITION_OFF=0, WAIT_DOOR_OPEN=1, WAIT_DOOR_CLOSE=2, START_ARM_DELAY=3.
  - `ignition` in any state → WAIT_IGNITION_OFF.
  - WAIT_IGNITION_OFF: `!ignition` → WAIT_DOOR_OPEN.
  - WAIT_DOOR_OPEN: `drv` → WAIT_DOOR_CLOSE.
  - WAIT_DOOR_CLOSE: `doors==0` (raw, unmasked) → START_ARM_DELAY.
  - START_ARM_DELAY: `|doors` → WAIT_DOOR_CLOSE.
- Timer: down-counter plus `running` flag.
  - `expired = running && one_hz_enable && timer_value==1` (combinational).
  - On a tick while running: decrement. Reaching 0 clears `running`.
  - Start loads the value and sets `running`. A start in the same cycle as a tick overrides the tick.
  - Starts: SET→TRIGGER loads `T_DRIVER` if `drv & zone_mask[DRIVER_IDX]`, else `T_PASS`. ON→STOP_ALARM loads `T_ALARM_ON`. In OFF, arming WAIT_DOOR_CLOSE→START_ARM_DELAY loads `T_ARM`, so re-closing the doors restarts the arm delay.
  - Clears (timer 0, not running): TRIGGER→ON, STOP_ALARM→ON, any transition to OFF or forced by `reprogram`.
- `trip_zone`:
  - Loaded with `act` on SET→TRIGGER.
  - In TRIGGER, ON or STOP_ALARM, OR-accumulates `act`.
  - Cleared on entry to OFF and on `reprogram`.
- `trip_count`: +1 on TRIGGER→ON, saturates at 15, cleared on entry to OFF.
- `status`:
  - SET: a blink flop toggled on each `one_hz_enable`, giving a 2 s period; the flop clears outside SET.
  - TRIGGER, ON, STOP_ALARM: 1.
  - OFF: 0.
- `enable_siren` = state is ON or STOP_ALARM.

## Timing
- All state, timer, `trip_*` and blink registers update on the rising `clock` edge.
- Outputs are decoded from registered state, so a condition at edge k is visible after edge k.
- Reset values: `state`=0 (SET), `arm_state`=0, `timer_value`=0, running=0, blink=0, `status`=0, `enable_siren`=0, `trip_zone`=0, `trip_count`=0.
- Entry delay: the alarm sounds on the cycle after the T-th `one_hz_enable` following the trigger cycle.
- Reset mid-count aborts immediately.
- `reprogram` held high keeps the block in SET with the timer idle.

## Test plan
- Reset, then drop `ignition` with `doors`=0001 then 0000, ticking 1 Hz → arm_state 1→2→3; OFF→SET after 6 ticks; `status` toggles each tick.
- In SET, `doors`=0100 (mask 1111) → TRIGGER, timer=15; at the 15th tick → ON, `enable_siren`=1, `trip_zone`=0100, `trip_count`=1.
- In SET, `doors`=0101 → timer loads 8 (driver priority). Mask 1110 with `doors`=0001 → no trigger.
- In ON, close all → STOP_ALARM, timer=10. Reopen at tick 4 → ON with timer cleared. Close, then at the 10th tick with a simultaneous door open → SET.
- In OFF, arm delay at count 3 when a door reopens → WAIT_DOOR_CLOSE. Close again → timer reloads to 6. `ignition` asserted mid-count → OFF, arm_state 0.
- Sixteen TRIGGER→ON cycles → `trip_count` holds at 15. Assert `reset` mid-alarm → all outputs return to their reset values.

Source files
------------

// File: rtl/alarm_ctrl_nzone.sv
// alarm_ctrl_nzone
// Multi-zone vehicle alarm controller with an integrated 1 Hz delay timer.
// The controller arms itself after the driver leaves and the doors close.
// Once armed, an opened zone starts an entry delay. When the delay expires
// the siren sounds. The siren is held for a while after all zones close,
// and the zones that tripped are latched.
//
// Ports:
//   clock, reset       system clock; asynchronous active-high reset
//   ignition           ignition on (disarms, forces OFF)
//   doors[N_DOORS]     1 = door/zone open (synchronous, debounced)
//   zone_mask[N_DOORS] 1 = zone may trigger the alarm
//   one_hz_enable      one-cycle pulse per second, timer/blink tick
//   reprogram          force the armed (SET) state
//   status             status LED
//   enable_siren       siren drive
//   state              main state code (SET=0 OFF=1 TRIGGER=2 ON=3 STOP_ALARM=4)
//   arm_state          arming state code
//   trip_zone          zones that caused or joined the current alarm
//   trip_count         saturating count of TRIGGER->ON events
//   timer_value        current delay timer count
module alarm_ctrl_nzone #(
  parameter int N_DOORS    = 4,
  parameter int DRIVER_IDX = 0,
  parameter int T_ARM      = 6,
  parameter int T_DRIVER   = 8,
  parameter int T_PASS     = 15,
  parameter int T_ALARM_ON = 10,
  parameter int TW         = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] doors,
  input  logic [N_DOORS-1:0] zone_mask,
  input  logic               one_hz_enable,
  input  logic               reprogram,
  output logic               status,
  output logic               enable_siren,
  output logic [2:0]         state,
  output logic [1:0]         arm_state,
  output logic [N_DOORS-1:0] trip_zone,
  output logic [3:0]         trip_count,
  output logic [TW-1:0]      timer_value
);

  typedef enum logic [2:0] {
    S_SET        = 3'd0,
    S_OFF        = 3'd1,
    S_TRIGGER    = 3'd2,
    S_ON         = 3'd3,
    S_STOP_ALARM = 3'd4
  } main_state_t;

  typedef enum logic [1:0] {
    A_WAIT_IGNITION_OFF = 2'd0,
    A_WAIT_DOOR_OPEN    = 2'd1,
    A_WAIT_DOOR_CLOSE   = 2'd2,
    A_START_ARM_DELAY   = 2'd3
  } arm_state_t;

  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] LOAD_ARM   = TW'(T_ARM);
  localparam logic [TW-1:0] LOAD_DRV   = TW'(T_DRIVER);
  localparam logic [TW-1:0] LOAD_PASS  = TW'(T_PASS);
  localparam logic [TW-1:0] LOAD_ALARM = TW'(T_ALARM_ON);

  main_state_t        state_q, state_d;
  arm_state_t         arm_q, arm_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               running_q, running_d;
  logic               blink_q, blink_d;
  logic [N_DOORS-1:0] trip_zone_q, trip_zone_d;
  logic [3:0]         trip_count_q, trip_count_d;

  logic [N_DOORS-1:0] act;
  logic               drv;
  logic               expired;
  logic               arm_restart;

  assign act     = doors & zone_mask;
  assign drv     = doors[DRIVER_IDX];
  assign expired = running_q && one_hz_enable && (timer_q == TIMER_ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_SET;
      arm_q        <= A_WAIT_IGNITION_OFF;
      timer_q      <= '0;
      running_q    <= 1'b0;
      blink_q      <= 1'b0;
      trip_zone_q  <= '0;
      trip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      arm_q        <= arm_d;
      timer_q      <= timer_d;
      running_q    <= running_d;
      blink_q      <= blink_d;
      trip_zone_q  <= trip_zone_d;
      trip_count_q <= trip_count_d;
    end
  end

  // Main state machine
  always_comb begin
    state_d = state_q;
    if (reprogram) begin
      state_d = S_SET;
    end else if (ignition) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_SET:        if (|act) state_d = S_TRIGGER;
        S_OFF:        if (expired && arm_q == A_START_ARM_DELAY) state_d = S_SET;
        S_TRIGGER:    if (expired) state_d = S_ON;
        S_ON:         if (act == '0) state_d = S_STOP_ALARM;
        S_STOP_ALARM: begin
          // Expiry wins over a door reopening on the same tick.
          if (expired)   state_d = S_SET;
          else if (|act) state_d = S_ON;
        end
        default:      state_d = S_SET;
      endcase
    end
  end

  // Arming state machine; runs regardless of the main state
  always_comb begin
    arm_d = arm_q;
    if (ignition) begin
      arm_d = A_WAIT_IGNITION_OFF;
    end else begin
      case (arm_q)
        A_WAIT_IGNITION_OFF: arm_d = A_WAIT_DOOR_OPEN;
        A_WAIT_DOOR_OPEN:    if (drv) arm_d = A_WAIT_DOOR_CLOSE;
        A_WAIT_DOOR_CLOSE:   if (doors == '0) arm_d = A_START_ARM_DELAY;
        A_START_ARM_DELAY:   if (|doors) arm_d = A_WAIT_DOOR_CLOSE;
        default:             arm_d = A_WAIT_IGNITION_OFF;
      endcase
    end
  end

  // Re-closing the doors while disarmed restarts the arm delay from the top.
  assign arm_restart = (state_q == S_OFF) && (arm_q == A_WAIT_DOOR_CLOSE) &&
                       (arm_d == A_START_ARM_DELAY);

  // Delay timer: loads and clears take precedence over the tick decrement
  always_comb begin
    timer_d   = timer_q;
    running_d = running_q;
    if (reprogram || ignition) begin
      timer_d   = '0;
      running_d = 1'b0;
    end else if (state_q == S_SET && state_d == S_TRIGGER) begin
      timer_d   = act[DRIVER_IDX] ? LOAD_DRV : LOAD_PASS;
      running_d = 1'b1;
    end else if (state_q == S_ON && state_d == S_STOP_ALARM) begin
      timer_d   = LOAD_ALARM;
      running_d = 1'b1;
    end else if (arm_restart) begin
      timer_d   = LOAD_ARM;
      running_d = 1'b1;
    end else if (state_d == S_ON &&
                 (state_q == S_TRIGGER || state_q == S_STOP_ALARM)) begin
      timer_d   = '0;
      running_d = 1'b0;
    end else if (running_q && one_hz_enable) begin
      timer_d = timer_q - TIMER_ONE;
      if (timer_q == TIMER_ONE) running_d = 1'b0;
    end
  end

  // Trip bookkeeping and status blink
  always_comb begin
    trip_zone_d  = trip_zone_q;
    trip_count_d = trip_count_q;
    blink_d      = (state_q == S_SET) ? (blink_q ^ one_hz_enable) : 1'b0;
    if (reprogram) begin
      trip_zone_d = '0;
    end else if (ignition) begin
      trip_zone_d  = '0;
      trip_count_d = '0;
    end else begin
      case (state_q)
        S_SET: if (state_d == S_TRIGGER) trip_zone_d = act;
        S_TRIGGER, S_ON, S_STOP_ALARM: trip_zone_d = trip_zone_q | act;
        default: ;
      endcase
      if (state_q == S_TRIGGER && state_d == S_ON && trip_count_q != 4'hF)
        trip_count_d = trip_count_q + 4'd1;
    end
  end

  // Output decode from registered state
  always_comb begin
    status = 1'b0;
    case (state_q)
      S_SET:                         status = blink_q;
      S_TRIGGER, S_ON, S_STOP_ALARM: status = 1'b1;
      default:                       status = 1'b0;
    endcase
  end

  assign enable_siren = (state_q == S_ON) || (state_q == S_STOP_ALARM);
  assign state        = state_q;
  assign arm_state    = arm_q;
  assign trip_zone    = trip_zone_q;
  assign trip_count   = trip_count_q;
  assign timer_value  = timer_q;

endmodule

// File: tb/tb_alarm_ctrl_nzone.sv
// tb_alarm_ctrl_nzone
// Directed bench for alarm_ctrl_nzone with default parameters. Expected
// outputs are queued as each cycle's stimulus is driven. They are popped
// and compared one time unit after the clock edge that applies the stimulus.
module tb_alarm_ctrl_nzone;

  localparam int N  = 4;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          ignition;
  logic [N-1:0]  doors;
  logic [N-1:0]  zone_mask;
  logic          one_hz_enable;
  logic          reprogram;
  logic          status;
  logic          enable_siren;
  logic [2:0]    state;
  logic [1:0]    arm_state;
  logic [N-1:0]  trip_zone;
  logic [3:0]    trip_count;
  logic [TW-1:0] timer_value;

  alarm_ctrl_nzone #(
    .N_DOORS   (N),
    .DRIVER_IDX(0),
    .T_ARM     (6),
    .T_DRIVER  (8),
    .T_PASS    (15),
    .T_ALARM_ON(10),
    .TW        (TW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ignition     (ignition),
    .doors        (doors),
    .zone_mask    (zone_mask),
    .one_hz_enable(one_hz_enable),
    .reprogram    (reprogram),
    .status       (status),
    .enable_siren (enable_siren),
    .state        (state),
    .arm_state    (arm_state),
    .trip_zone    (trip_zone),
    .trip_count   (trip_count),
    .timer_value  (timer_value)
  );

  always #5 clock = ~clock;

  typedef enum int {F_STATE, F_ARM, F_TIMER, F_STATUS, F_SIREN, F_TZ, F_TC} field_t;
  typedef struct {
    string       tag;
    field_t      f;
    int unsigned exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int unsigned observe(input field_t f);
    case (f)
      F_STATE:  return int'(state);
      F_ARM:    return int'(arm_state);
      F_TIMER:  return int'(timer_value);
      F_STATUS: return int'(status);
      F_SIREN:  return int'(enable_siren);
      F_TZ:     return int'(trip_zone);
      default:  return int'(trip_count);
    endcase
  endfunction

  task automatic want(input string tag, input field_t f, input int unsigned v);
    sb.push_back('{tag, f, v});
  endtask

  // One clock with optional 1 Hz tick, then drain the scoreboard.
  task automatic cyc(input logic tk);
    one_hz_enable = tk;
    @(posedge clock);
    #1;
    one_hz_enable = 1'b0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val(e.tag, observe(e.f), e.exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, int'(state), 0);
    check_val({tag, "_arm"},   int'(arm_state), 0);
    check_val({tag, "_timer"}, int'(timer_value), 0);
    check_val({tag, "_status"}, int'(status), 0);
    check_val({tag, "_siren"}, int'(enable_siren), 0);
    check_val({tag, "_tzone"}, int'(trip_zone), 0);
    check_val({tag, "_tcount"}, int'(trip_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ignition = 1'b1; doors = '0; zone_mask = '1;
    one_hz_enable = 1'b0; reprogram = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Arming sequence after the driver leaves
    want("off_state", F_STATE, 1); want("arm_wio", F_ARM, 0); cyc(0);
    ignition = 1'b0; doors = 4'b0001;
    want("arm_wdo", F_ARM, 1); cyc(0);
    want("arm_wdc", F_ARM, 2); cyc(0);
    doors = 4'b0000;
    want("arm_sad", F_ARM, 3); want("arm_load", F_TIMER, 6); cyc(0);
    for (int k = 1; k <= 5; k++) begin
      want("arm_cnt", F_TIMER, 6 - k); want("arm_off", F_STATE, 1);
      want("off_led", F_STATUS, 0); cyc(1);
    end
    want("armed", F_STATE, 0); want("armed_tmr", F_TIMER, 0);
    want("armed_led", F_STATUS, 0); cyc(1);
    want("blink1", F_STATUS, 1); cyc(1);
    want("blink_hold", F_STATUS, 1); cyc(0);
    want("blink0", F_STATUS, 0); cyc(1);

    // Passenger zone trigger and entry delay
    doors = 4'b0100;
    want("trig", F_STATE, 2); want("trig_tmr", F_TIMER, 15);
    want("trig_zone", F_TZ, 4'b0100); want("trig_led", F_STATUS, 1);
    want("trig_siren", F_SIREN, 0); cyc(0);
    for (int k = 1; k <= 14; k++) begin
      want("entry_cnt", F_TIMER, 15 - k); want("entry_state", F_STATE, 2); cyc(1);
    end
    want("alarm_on", F_STATE, 3); want("alarm_siren", F_SIREN, 1);
    want("alarm_zone", F_TZ, 4'b0100); want("alarm_count", F_TC, 1);
    want("alarm_tmr", F_TIMER, 0); cyc(1);

    // Siren hold, reopen, and expiry against a simultaneous opening
    doors = 4'b0000;
    want("stop", F_STATE, 4); want("stop_tmr", F_TIMER, 10); want("stop_siren", F_SIREN, 1); cyc(0);
    for (int k = 1; k <= 3; k++) begin
      want("hold_cnt", F_TIMER, 10 - k); cyc(1);
    end
    doors = 4'b0010;
    want("reopen", F_STATE, 3); want("reopen_tmr", F_TIMER, 0);
    want("reopen_zone", F_TZ, 4'b0110); want("reopen_count", F_TC, 1); cyc(1);
    doors = 4'b0000;
    want("stop2", F_STATE, 4); want("stop2_tmr", F_TIMER, 10); cyc(0);
    for (int k = 1; k <= 9; k++) begin
      want("hold2_cnt", F_TIMER, 10 - k); want("hold2_state", F_STATE, 4); cyc(1);
    end
    doors = 4'b1000;
    want("rearm", F_STATE, 0); want("rearm_tmr", F_TIMER, 0);
    want("rearm_zone", F_TZ, 4'b1110); want("rearm_siren", F_SIREN, 0);
    want("rearm_led", F_STATUS, 0); cyc(1);
    doors = 4'b0000;
    want("rearm_idle", F_STATE, 0); cyc(0);

    // Driver delay priority, reprogram, and masked zones
    doors = 4'b0101;
    want("drv_trig", F_STATE, 2); want("drv_tmr", F_TIMER, 8); want("drv_zone", F_TZ, 4'b0101); cyc(0);
    doors = 4'b0000; reprogram = 1'b1;
    want("rp_state", F_STATE, 0); want("rp_tmr", F_TIMER, 0);
    want("rp_zone", F_TZ, 0); want("rp_count", F_TC, 1); cyc(0);
    doors = 4'b0100;
    want("rp_hold", F_STATE, 0); want("rp_hold_tmr", F_TIMER, 0); cyc(1);
    reprogram = 1'b0; zone_mask = 4'b1110; doors = 4'b0001;
    want("mask_idle", F_STATE, 0); want("mask_tmr", F_TIMER, 0); cyc(0);
    doors = 4'b0011;
    want("mask_trig", F_STATE, 2); want("mask_pass_tmr", F_TIMER, 15); want("mask_zone", F_TZ, 4'b0010); cyc(0);
    doors = 4'b0000; zone_mask = '1; reprogram = 1'b1;
    want("rp2", F_STATE, 0); cyc(0);
    reprogram = 1'b0;

    // Arm delay restart while disarmed, then ignition abort
    ignition = 1'b1;
    want("ign_off", F_STATE, 1); want("ign_arm", F_ARM, 0);
    want("ign_count", F_TC, 0); want("ign_zone", F_TZ, 0); want("ign_tmr", F_TIMER, 0); cyc(0);
    ignition = 1'b0; doors = 4'b0001;
    want("re_wdo", F_ARM, 1); cyc(0);
    want("re_wdc", F_ARM, 2); cyc(0);
    doors = 4'b0000;
    want("re_sad", F_ARM, 3); want("re_load", F_TIMER, 6); cyc(0);
    for (int k = 1; k <= 3; k++) begin
      want("re_cnt", F_TIMER, 6 - k); cyc(1);
    end
    doors = 4'b0010;
    want("reopen_arm", F_ARM, 2); want("reopen_arm_tmr", F_TIMER, 3); cyc(0);
    doors = 4'b0000;
    want("reclose_arm", F_ARM, 3); want("reload_tmr", F_TIMER, 6); cyc(0);
    want("reload_cnt", F_TIMER, 5); cyc(1);
    ignition = 1'b1;
    want("abort_state", F_STATE, 1); want("abort_arm", F_ARM, 0); want("abort_tmr", F_TIMER, 0); cyc(1);
    ignition = 1'b0;

    // Sixteen alarms: count saturates at 15
    for (int i = 0; i < 16; i++) begin
      reprogram = 1'b1; doors = 4'b0000;
      want("sat_set", F_STATE, 0); cyc(0);
      reprogram = 1'b0; doors = 4'b0100;
      want("sat_trig", F_STATE, 2); cyc(0);
      repeat (14) cyc(1);
      want("sat_on", F_STATE, 3);
      want("sat_count", F_TC, (i + 1 > 15) ? 15 : i + 1);
      cyc(1);
    end

    // Asynchronous reset in the middle of an alarm
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
